// File: rtl/ssc_pkg.sv
// rtl/ssc_pkg.sv - shared types, profile codes and width defaults for the SSC sequencer
package ssc_pkg;

  localparam int SSC_PHASE_BITS_DEF    = 16;
  localparam int SSC_AMP_BITS_DEF      = 8;
  localparam int SSC_RAMP_STEP_DEF     = 16;
  localparam int SSC_RAMP_DIV_DEF      = 4;
  localparam int SSC_CALIB_TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    SSC_ST_IDLE      = 3'd0,
    SSC_ST_CALIB     = 3'd1,
    SSC_ST_RAMP_UP   = 3'd2,
    SSC_ST_ACTIVE    = 3'd3,
    SSC_ST_RAMP_DOWN = 3'd4
  } ssc_seq_state_e;

  // What to do once a ramp-down reaches its target.
  typedef enum logic [1:0] {
    SSC_MODE_NORM    = 2'd0,
    SSC_MODE_DISABLE = 2'd1,
    SSC_MODE_REAPPLY = 2'd2
  } ssc_ramp_mode_e;

  localparam logic [1:0] SSC_PROF_TRI  = 2'd0;
  localparam logic [1:0] SSC_PROF_DDS  = 2'd1;
  localparam logic [1:0] SSC_PROF_CUST = 2'd2;

  function automatic logic is_ramp_state(input logic [2:0] s);
    return (s == SSC_ST_RAMP_UP) || (s == SSC_ST_RAMP_DOWN);
  endfunction

endpackage

// File: rtl/ssc_ramp_gen.sv
// rtl/ssc_ramp_gen.sv - tick divider plus saturating up/down modulation depth register
module ssc_ramp_gen #(
  parameter int N_AMP_BITS = 8,
  parameter int RAMP_STEP  = 16,
  parameter int RAMP_DIV   = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  run,
  input  logic                  up,
  input  logic                  clear,
  input  logic [N_AMP_BITS-1:0] target,
  output logic [N_AMP_BITS-1:0] depth,
  output logic                  at_target
);

  localparam int                DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LOAD = DIV_W'(RAMP_DIV - 1);
  localparam logic [N_AMP_BITS:0] STEP   = (N_AMP_BITS + 1)'(RAMP_STEP);

  logic [DIV_W-1:0]      div_q, div_d;
  logic [N_AMP_BITS-1:0] depth_q, depth_d;
  logic [N_AMP_BITS:0]   depth_ext, tgt_ext, sum, diff;
  logic                  tick;

  always_comb begin
    depth_ext = {1'b0, depth_q};
    tgt_ext   = {1'b0, target};
    // One extra bit keeps the sum from wrapping and exposes underflow on subtract.
    sum       = depth_ext + STEP;
    diff      = depth_ext - STEP;
    tick      = run && (div_q == '0);
    div_d     = div_q;
    depth_d   = depth_q;
    if (start) begin
      div_d = DIV_LOAD;
    end else if (run) begin
      div_d = tick ? DIV_LOAD : div_q - DIV_W'(1);
    end
    if (clear) begin
      depth_d = '0;
    end else if (tick && !start) begin
      if (up) begin
        depth_d = (sum >= tgt_ext) ? target : sum[N_AMP_BITS-1:0];
      end else begin
        depth_d = ((depth_ext < STEP) || (diff <= tgt_ext)) ? target : diff[N_AMP_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      depth_q <= '0;
    end else begin
      div_q   <= div_d;
      depth_q <= depth_d;
    end
  end

  assign depth     = depth_q;
  assign at_target = (depth_q == target);

endmodule

// File: rtl/ssc_seq_ctrl.sv
// rtl/ssc_seq_ctrl.sv - SSC modulator sequencing controller; optional SSC_SEQ_CALIB_TIMEOUT_EN
// Owns all modulator controls; depth changes are always ramped, profile/freq change only at depth 0.
module ssc_seq_ctrl
  import ssc_pkg::*;
#(
  parameter int N_PHASE_BITS  = SSC_PHASE_BITS_DEF,
  parameter int N_AMP_BITS    = SSC_AMP_BITS_DEF,
  parameter int RAMP_STEP     = SSC_RAMP_STEP_DEF,
  parameter int RAMP_DIV      = SSC_RAMP_DIV_DEF,
  parameter int CALIB_TIMEOUT = SSC_CALIB_TIMEOUT_DEF
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic                    cfg_en,
  input  logic [1:0]              cfg_profile,
  input  logic [N_AMP_BITS-1:0]   cfg_depth,
  input  logic [N_PHASE_BITS-1:0] cfg_freq,
  output logic                    mod_en,
  output logic [1:0]              mod_profile,
  output logic [N_AMP_BITS-1:0]   mod_depth,
  output logic [N_PHASE_BITS-1:0] mod_freq,
  output logic                    mod_calib_req,
  input  logic                    mod_calib_done,
  output logic [2:0]              seq_state,
  output logic                    seq_busy,
  output logic                    seq_done,
  output logic                    seq_err
);

  localparam logic [2:0] ST_IDLE      = SSC_ST_IDLE;
  localparam logic [2:0] ST_CALIB     = SSC_ST_CALIB;
  localparam logic [2:0] ST_RAMP_UP   = SSC_ST_RAMP_UP;
  localparam logic [2:0] ST_ACTIVE    = SSC_ST_ACTIVE;
  localparam logic [2:0] ST_RAMP_DOWN = SSC_ST_RAMP_DOWN;

  logic [2:0]              state_q, state_d;
  ssc_ramp_mode_e          mode_q, mode_d;
  logic [N_AMP_BITS-1:0]   target_q, target_d;
  logic                    xfer, xfer_q, xfer_d;
  logic                    sh_en_q, sh_en_d;
  logic [1:0]              sh_profile_q, sh_profile_d;
  logic [N_AMP_BITS-1:0]   sh_depth_q, sh_depth_d;
  logic [N_PHASE_BITS-1:0] sh_freq_q, sh_freq_d;
  logic                    mod_en_q, mod_en_d;
  logic [1:0]              mod_profile_q, mod_profile_d;
  logic [N_PHASE_BITS-1:0] mod_freq_q, mod_freq_d;
  logic                    done_q, done_d;
  logic                    ramp_start, ramp_clear, ramp_run, ramp_up, at_target;
  logic [N_AMP_BITS-1:0]   ramp_depth;
  logic                    cal_timeout;

  // Ready drops for the one cycle the FSM spends acting on a fresh shadow.
  assign cfg_ready = ((state_q == ST_IDLE) || (state_q == ST_ACTIVE)) && !xfer_q;
  assign xfer      = cfg_valid && cfg_ready;
  assign ramp_run  = is_ramp_state(state_q);
  assign ramp_up   = (state_q == ST_RAMP_UP);

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    target_d      = target_q;
    mod_en_d      = mod_en_q;
    mod_profile_d = mod_profile_q;
    mod_freq_d    = mod_freq_q;
    done_d        = 1'b0;
    ramp_clear    = 1'b0;
    xfer_d        = xfer;
    sh_en_d       = sh_en_q;
    sh_profile_d  = sh_profile_q;
    sh_depth_d    = sh_depth_q;
    sh_freq_d     = sh_freq_q;
    if (xfer) begin
      sh_en_d      = cfg_en;
      sh_profile_d = cfg_profile;
      sh_depth_d   = cfg_depth;
      sh_freq_d    = cfg_freq;
    end
    case (state_q)
      ST_IDLE: begin
        if (xfer_q && sh_en_q) state_d = ST_CALIB;
      end
      ST_CALIB: begin
        if (mod_calib_done) begin
          state_d       = ST_RAMP_UP;
          mode_d        = SSC_MODE_NORM;
          target_d      = sh_depth_q;
          mod_en_d      = 1'b1;
          mod_profile_d = sh_profile_q;
          mod_freq_d    = sh_freq_q;
          ramp_clear    = 1'b1;
        end else if (cal_timeout) begin
          state_d  = ST_IDLE;
          mod_en_d = 1'b0;
        end
      end
      ST_RAMP_UP: begin
        if (at_target) begin
          state_d = ST_ACTIVE;
          done_d  = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (xfer_q) begin
          if (!sh_en_q) begin
            state_d  = ST_RAMP_DOWN;
            target_d = '0;
            mode_d   = SSC_MODE_DISABLE;
          end else if ((sh_profile_q != mod_profile_q) || (sh_freq_q != mod_freq_q)) begin
            state_d  = ST_RAMP_DOWN;
            target_d = '0;
            mode_d   = SSC_MODE_REAPPLY;
          end else if (sh_depth_q > ramp_depth) begin
            state_d  = ST_RAMP_UP;
            target_d = sh_depth_q;
            mode_d   = SSC_MODE_NORM;
          end else if (sh_depth_q < ramp_depth) begin
            state_d  = ST_RAMP_DOWN;
            target_d = sh_depth_q;
            mode_d   = SSC_MODE_NORM;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RAMP_DOWN: begin
        if (at_target) begin
          case (mode_q)
            SSC_MODE_DISABLE: begin
              state_d  = ST_IDLE;
              mod_en_d = 1'b0;
              done_d   = 1'b1;
            end
            SSC_MODE_REAPPLY: begin
              // Depth is 0 here, so swapping profile/freq cannot cause a jump.
              state_d       = ST_RAMP_UP;
              mode_d        = SSC_MODE_NORM;
              target_d      = sh_depth_q;
              mod_profile_d = sh_profile_q;
              mod_freq_d    = sh_freq_q;
            end
            default: begin
              state_d = ST_ACTIVE;
              done_d  = 1'b1;
            end
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ramp_start = is_ramp_state(state_d) && (state_d != state_q);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      mode_q        <= SSC_MODE_NORM;
      target_q      <= '0;
      xfer_q        <= 1'b0;
      sh_en_q       <= 1'b0;
      sh_profile_q  <= '0;
      sh_depth_q    <= '0;
      sh_freq_q     <= '0;
      mod_en_q      <= 1'b0;
      mod_profile_q <= '0;
      mod_freq_q    <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      target_q      <= target_d;
      xfer_q        <= xfer_d;
      sh_en_q       <= sh_en_d;
      sh_profile_q  <= sh_profile_d;
      sh_depth_q    <= sh_depth_d;
      sh_freq_q     <= sh_freq_d;
      mod_en_q      <= mod_en_d;
      mod_profile_q <= mod_profile_d;
      mod_freq_q    <= mod_freq_d;
      done_q        <= done_d;
    end
  end

`ifdef SSC_SEQ_CALIB_TIMEOUT_EN
  localparam int CAL_W = $clog2(CALIB_TIMEOUT + 1);

  logic [CAL_W-1:0] cal_cnt_q, cal_cnt_d;
  logic             err_q, err_d;

  assign cal_timeout = (cal_cnt_q == CAL_W'(CALIB_TIMEOUT - 1));

  always_comb begin
    cal_cnt_d = (state_q == ST_CALIB) ? cal_cnt_q + CAL_W'(1) : '0;
    err_d     = err_q;
    if (xfer) begin
      err_d = 1'b0;
    end else if ((state_q == ST_CALIB) && !mod_calib_done && cal_timeout) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cal_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      cal_cnt_q <= cal_cnt_d;
      err_q     <= err_d;
    end
  end

  assign seq_err = err_q;
`else
  assign cal_timeout = 1'b0;
  assign seq_err     = 1'b0;
`endif

  ssc_ramp_gen #(
    .N_AMP_BITS (N_AMP_BITS),
    .RAMP_STEP  (RAMP_STEP),
    .RAMP_DIV   (RAMP_DIV)
  ) u_ramp (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .start     (ramp_start),
    .run       (ramp_run),
    .up        (ramp_up),
    .clear     (ramp_clear),
    .target    (target_q),
    .depth     (ramp_depth),
    .at_target (at_target)
  );

  assign mod_en        = mod_en_q;
  assign mod_profile   = mod_profile_q;
  assign mod_depth     = ramp_depth;
  assign mod_freq      = mod_freq_q;
  assign mod_calib_req = (state_q == ST_CALIB);
  assign seq_state     = state_q;
  assign seq_busy      = !((state_q == ST_IDLE) || (state_q == ST_ACTIVE));
  assign seq_done      = done_q;

endmodule

// File: tb/tb_ssc_seq_ctrl.sv
// tb/tb_ssc_seq_ctrl.sv - self-checking bench for ssc_seq_ctrl against a depth-formula model
module tb_ssc_seq_ctrl;

  localparam int NP = 16, NA = 8, STEP = 16, DIV = 4, CTO = 32;

  logic          clk_in = 1'b0, rst_n = 1'b0;
  logic          cfg_valid = 1'b0, cfg_en = 1'b0, mod_calib_done = 1'b0;
  logic [1:0]    cfg_profile = '0;
  logic [NA-1:0] cfg_depth = '0;
  logic [NP-1:0] cfg_freq = '0;
  logic          cfg_ready, mod_en, mod_calib_req, seq_busy, seq_done, seq_err;
  logic [1:0]    mod_profile;
  logic [NA-1:0] mod_depth;
  logic [NP-1:0] mod_freq;
  logic [2:0]    seq_state;

  int n_assert = 0, n_fail = 0;
  int cur_prof = 0, cur_freq = 0, cur_depth = 0;

  ssc_seq_ctrl #(.N_PHASE_BITS(NP), .N_AMP_BITS(NA), .RAMP_STEP(STEP), .RAMP_DIV(DIV),
                 .CALIB_TIMEOUT(CTO)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_en(cfg_en), .cfg_profile(cfg_profile), .cfg_depth(cfg_depth), .cfg_freq(cfg_freq),
    .mod_en(mod_en), .mod_profile(mod_profile), .mod_depth(mod_depth), .mod_freq(mod_freq),
    .mod_calib_req(mod_calib_req), .mod_calib_done(mod_calib_done), .seq_state(seq_state),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_err(seq_err)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic wait_state(input int st, input int limit, input string tag);
    int n = 0;
    while (seq_state != st[2:0] && n < limit) begin
      @(negedge clk_in);
      n++;
    end
    chk(tag, seq_state, st);
  endtask

  task automatic do_xfer(input bit en, input int p, input int d, input int f, output int waited);
    waited = 0;
    @(negedge clk_in);
    cfg_valid = 1'b1; cfg_en = en; cfg_profile = p[1:0]; cfg_depth = d[NA-1:0]; cfg_freq = f[NP-1:0];
    while (!cfg_ready && waited < 400) begin
      @(negedge clk_in);
      waited++;
    end
    chk("xfer_ready", cfg_ready, 1);
    @(negedge clk_in);
    cfg_valid = 1'b0;
  endtask

  task automatic calib_respond(input int dly);
    wait_state(1, 20, "calib_entry");
    chk("calib_req", mod_calib_req, 1);
    chk("calib_busy", seq_busy, 1);
    chk("calib_not_ready", cfg_ready, 0);
    chk("calib_mod_en_low", mod_en, 0);
    repeat (dly) @(negedge clk_in);
    chk("calib_req_held", mod_calib_req, 1);
    mod_calib_done = 1'b1;
    @(negedge clk_in);
    mod_calib_done = 1'b0;
    chk("calib_req_drop", mod_calib_req, 0);
    chk("calib_mod_en", mod_en, 1);
  endtask

  // Depth k cycles after ramp entry is start +/- STEP*floor(k/DIV), clamped at the target.
  task automatic run_ramp(input int from, input int tgt, input bit up, input int eprof,
                          input int enext, input bit edone);
    int k = 0;
    int e;
    int st = up ? 2 : 4;
    wait_state(st, 20, "ramp_entry");
    while (seq_state == st[2:0] && k < 300) begin
      e = up ? imin(from + STEP * (k / DIV), tgt) : imax(from - STEP * (k / DIV), tgt);
      chk("ramp_depth", mod_depth, e);
      chk("ramp_profile", mod_profile, eprof);
      chk("ramp_done_low", seq_done, 0);
      k++;
      @(negedge clk_in);
    end
    chk("ramp_exit_state", seq_state, enext);
    chk("ramp_exit_depth", mod_depth, tgt);
    chk("ramp_exit_done", seq_done, edone);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 6; i++) begin
      if (seq_done) break;
      @(negedge clk_in);
    end
    chk(tag, seq_done, 1);
  endtask

  task automatic apply_cfg(input bit en, input int p, input int d, input int f);
    int w;
    do_xfer(en, p, d, f, w);
    if (!en) begin
      run_ramp(cur_depth, 0, 1'b0, cur_prof, 0, 1'b1);
      chk("disable_mod_en", mod_en, 0);
      cur_depth = 0;
    end else if (p != cur_prof || f != cur_freq) begin
      run_ramp(cur_depth, 0, 1'b0, cur_prof, 2, 1'b0);
      chk("reapply_profile", mod_profile, p);
      chk("reapply_freq", mod_freq, f);
      run_ramp(0, d, 1'b1, p, 3, 1'b1);
      cur_prof = p; cur_freq = f; cur_depth = d;
    end else if (d > cur_depth) begin
      run_ramp(cur_depth, d, 1'b1, p, 3, 1'b1);
      cur_depth = d;
    end else if (d < cur_depth) begin
      run_ramp(cur_depth, d, 1'b0, p, 3, 1'b1);
      cur_depth = d;
    end else begin
      wait_done("same_cfg_done");
      chk("same_cfg_state", seq_state, 3);
      chk("same_cfg_depth", mod_depth, d);
    end
  endtask

  initial begin
    int w, w2, n;
    int p, d, f;
    bit en_seen;

    repeat (3) @(negedge clk_in);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_mod_en", mod_en, 0);
    chk("rst_mod_profile", mod_profile, 0);
    chk("rst_mod_depth", mod_depth, 0);
    chk("rst_mod_freq", mod_freq, 0);
    chk("rst_calib_req", mod_calib_req, 0);
    chk("rst_state", seq_state, 0);
    chk("rst_busy", seq_busy, 0);
    chk("rst_done", seq_done, 0);
    chk("rst_err", seq_err, 0);
    rst_n = 1'b1;

    do_xfer(1'b1, 0, 'h40, 'h1234, w);
    calib_respond(5);
    run_ramp(0, 'h40, 1'b1, 0, 3, 1'b1);
    cur_prof = 0; cur_freq = 'h1234; cur_depth = 'h40;
    chk("active_ready", cfg_ready, 1);
    chk("active_mod_en", mod_en, 1);
    chk("active_freq", mod_freq, 'h1234);
    chk("active_busy", seq_busy, 0);

    mod_calib_done = 1'b1;
    repeat (2) @(negedge clk_in);
    mod_calib_done = 1'b0;
    chk("stray_done_state", seq_state, 3);
    chk("stray_done_req", mod_calib_req, 0);
    chk("stray_done_depth", mod_depth, 'h40);

    apply_cfg(1'b1, 0, 'h20, 'h1234);
    chk("down_mod_en", mod_en, 1);

    // A request held while busy must wait and then be taken once ACTIVE.
    do_xfer(1'b1, 0, 'h45, 'h1234, w);
    fork
      run_ramp('h20, 'h45, 1'b1, 0, 3, 1'b1);
      do_xfer(1'b1, 0, 'h45, 'h1234, w2);
    join
    cur_depth = 'h45;
    chk("pending_waited", (w2 > 4) ? 1 : 0, 1);
    wait_done("pending_same_done");
    chk("pending_state", seq_state, 3);

    apply_cfg(1'b1, 1, 'h45, 'h1234);
    apply_cfg(1'b1, 1, 'h45, 'h1234);

    for (int i = 0; i < 6; i++) begin
      p = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2)) : cur_prof;
      f = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 65535)) : cur_freq;
      d = ($urandom_range(0, 5) == 0) ? cur_depth : int'($urandom_range(0, 255));
      apply_cfg(1'b1, p, d, f);
    end

    apply_cfg(1'b0, cur_prof, 'h33, cur_freq);
    chk("off_state", seq_state, 0);
    chk("off_depth", mod_depth, 0);

    do_xfer(1'b0, 2, 'h10, 'h55, w);
    repeat (3) @(negedge clk_in);
    chk("idle_en0_state", seq_state, 0);
    chk("idle_en0_mod_en", mod_en, 0);
    chk("idle_en0_calib_req", mod_calib_req, 0);

    do_xfer(1'b1, 0, 'h40, 'h1234, w);
    calib_respond(2);
    n = 0;
    while (mod_depth != 8'd32 && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    chk("mid_ramp_depth", mod_depth, 32);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mod_en", mod_en, 0);
    chk("async_rst_depth", mod_depth, 0);
    chk("async_rst_state", seq_state, 0);
    chk("async_rst_ready", cfg_ready, 1);
    @(negedge clk_in);
    rst_n = 1'b1;
    cur_prof = 0; cur_freq = 0; cur_depth = 0;

`ifdef SSC_SEQ_CALIB_TIMEOUT_EN
    do_xfer(1'b1, 0, 'h40, 'h1234, w);
    wait_state(1, 20, "to_calib_entry");
    n = 0;
    en_seen = 1'b0;
    while (mod_calib_req && n < 100) begin
      if (mod_en) en_seen = 1'b1;
      @(negedge clk_in);
      n++;
    end
    chk("to_req_cycles", n, CTO);
    chk("to_err", seq_err, 1);
    chk("to_state", seq_state, 0);
    chk("to_req_low", mod_calib_req, 0);
    chk("to_mod_en_seen", en_seen, 0);
    do_xfer(1'b0, 0, 0, 0, w);
    chk("to_err_cleared", seq_err, 0);
`else
    en_seen = 1'b0;
    chk("err_tied_low", seq_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
